// File: rtl/jtag_master_if.sv
// Command/response port of the JTAG scan engine.
// A command transfers on a clk edge with cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
interface jtag_master_if #(
  parameter int DR_WIDTH = 41,
  parameter int LEN_W    = 6
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_is_ir;
  logic [LEN_W-1:0]    cmd_len;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;

  modport master (output cmd_valid, cmd_is_ir, cmd_len, cmd_data,
                  input  cmd_ready, rsp_valid, rsp_data);
  modport slave  (input  cmd_valid, cmd_is_ir, cmd_len, cmd_data,
                  output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/jtag_master.sv
// JTAG host scan engine: IR/DR scans with divided TCK, LSB-first shift, TDO capture.
// Optional JTAG_MASTER_IDLE_CYCLES_EN adds IDLE_CYCLES Run-Test/Idle TCK cycles after each scan.
module jtag_master #(
  parameter int DR_WIDTH    = 41,
  parameter int LEN_W       = 6,
  parameter int CLK_DIV     = 2,
  parameter int IDLE_CYCLES = 0
) (
  input  logic         clk,
  input  logic         TRST,
  jtag_master_if.slave bus,
  output logic         TCK,
  output logic         TMS,
  output logic         TDI,
  input  logic         TDO,
  output logic [2:0]   dbg_state,
  output logic [3:0]   dbg_tap
);
  localparam int STEP_MAX = (IDLE_CYCLES > DR_WIDTH) ? IDLE_CYCLES : DR_WIDTH;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    RST_SEQ, IDLE, SCAN_HDR, SHIFT, SCAN_TAIL,
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
    RTI_PAD,
`endif
    RESP
  } state_t;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  state_t              state, state_n;
  tap_t                tap, tap_n;
  logic                boot, boot_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic [CNT_W-1:0]    step, step_n, len, len_n, len_c, len_last, hdr_last;
  logic                tck_n, tms_n, tdi_n, is_ir, is_ir_n, rise, fall;
  logic [DR_WIDTH-1:0] data, data_n, cap, cap_n, rsp_q, rsp_n;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_q;
  assign dbg_state     = state;
  assign dbg_tap       = tap;
  assign len_last      = len - ONE;
  assign hdr_last      = is_ir ? CNT_W'(3) : CNT_W'(2);

  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      state <= RST_SEQ; tap <= TLR; boot <= 1'b1; div_cnt <= '0; step <= '0;
      TCK <= 1'b0; TMS <= 1'b1; TDI <= 1'b0; is_ir <= 1'b0; len <= '0;
      data <= '0; cap <= '0; rsp_q <= '0;
    end else begin
      state <= state_n; tap <= tap_n; boot <= boot_n; div_cnt <= div_n; step <= step_n;
      TCK <= tck_n; TMS <= tms_n; TDI <= tdi_n; is_ir <= is_ir_n; len <= len_n;
      data <= data_n; cap <= cap_n; rsp_q <= rsp_n;
    end
  end

  always_comb begin
    state_n = state; tap_n = tap; boot_n = 1'b0; div_n = div_cnt; step_n = step;
    tck_n = TCK; tms_n = TMS; tdi_n = TDI; is_ir_n = is_ir; len_n = len;
    data_n = data; cap_n = cap; rsp_n = rsp_q; rise = 1'b0; fall = 1'b0;
    len_c = (int'(bus.cmd_len) > DR_WIDTH) ? CNT_W'(DR_WIDTH) : CNT_W'(bus.cmd_len);

    // The first clk after reset release is spent arming, so the first low phase is a full one.
    if (state != IDLE && state != RESP && !boot) begin
      if (div_cnt == DIV_LAST) begin
        div_n = '0;
        tck_n = ~TCK;
        rise  = ~TCK;
        fall  = TCK;
      end else begin
        div_n = div_cnt + DIV_ONE;
      end
    end
    if (rise) tap_n = tap_next(tap, TMS);
    if (rise && state == SHIFT) cap_n[step] = TDO;

    // Every "fall" ends a TCK bit cycle and sets TMS/TDI for the next low phase.
    case (state)
      RST_SEQ: if (fall) begin
        if (step == CNT_W'(5)) begin
          state_n = IDLE;
          step_n  = '0;
        end else begin
          step_n = step + ONE;
          tms_n  = (step != CNT_W'(4));
        end
      end
      IDLE: if (bus.cmd_valid) begin
        is_ir_n = bus.cmd_is_ir;
        len_n   = len_c;
        data_n  = bus.cmd_data;
        cap_n   = '0;
        div_n   = '0;
        step_n  = '0;
        if (len_c == '0) begin
          state_n = RESP;
          rsp_n   = '0;
        end else begin
          state_n = SCAN_HDR;
          tms_n   = 1'b1;
        end
      end
      SCAN_HDR: if (fall) begin
        if (step == hdr_last) begin
          state_n = SHIFT;
          step_n  = '0;
          tdi_n   = data[0];
          tms_n   = (len == ONE);
        end else begin
          step_n = step + ONE;
          tms_n  = is_ir && (step == '0);
        end
      end
      SHIFT: if (fall) begin
        if (step == len_last) begin
          state_n = SCAN_TAIL;
          step_n  = '0;
          tms_n   = 1'b1;
          tdi_n   = 1'b0;
        end else begin
          step_n = step + ONE;
          tdi_n  = data[step_n];
          tms_n  = (step_n == len_last);
        end
      end
      SCAN_TAIL: if (fall) begin
        tms_n = 1'b0;
        if (step == '0) begin
          step_n = ONE;
        end else begin
          step_n = '0;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
          if (IDLE_CYCLES > 0) begin
            state_n = RTI_PAD;
          end else begin
            state_n = RESP;
            rsp_n   = cap;
          end
`else
          state_n = RESP;
          rsp_n   = cap;
`endif
        end
      end
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
      RTI_PAD: if (fall) begin
        if (step == CNT_W'(IDLE_CYCLES - 1)) begin
          state_n = RESP;
          step_n  = '0;
          rsp_n   = cap;
        end else begin
          step_n = step + ONE;
        end
      end
`endif
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_jtag_master.sv
// Directed and randomized scans of jtag_master against a scan-level reference model.
module tb_jtag_master;
  localparam int DR_WIDTH    = 41;
  localparam int LEN_W       = 6;
  localparam int CLK_DIV     = 2;
  localparam int IDLE_CYCLES = 3;
  localparam int TCK_CLKS    = 2 * CLK_DIV;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
  localparam int PAD = IDLE_CYCLES;
`else
  localparam int PAD = 0;
`endif

  // clock / reset
  logic clk  = 1'b0;
  logic trst = 1'b1;
  logic tck, tms, tdi, tdo;
  logic [2:0] dbg_state;
  logic [3:0] dbg_tap;
  always #5 clk = ~clk;

  jtag_master_if #(.DR_WIDTH(DR_WIDTH), .LEN_W(LEN_W)) bus ();

  jtag_master #(
    .DR_WIDTH(DR_WIDTH), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk(clk), .TRST(trst), .bus(bus), .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo),
    .dbg_state(dbg_state), .dbg_tap(dbg_tap)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [DR_WIDTH-1:0] exp_q[$];
  logic tms_log[$];
  logic tdi_log[$];
  int   rsp_count = 0;

  // target side: either a TDI->TDO loopback flop or a scripted TDO stream indexed by rise number
  logic [127:0] tdo_stream = '0;
  logic loop_mode  = 1'b0;
  logic loop_ff    = 1'b0;
  logic stream_bit = 1'b0;
  event cmd_start;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    loop_ff <= tdi;
  end
  always @(negedge tck or cmd_start) stream_bit = tdo_stream[tms_log.size()];
  assign tdo = loop_mode ? loop_ff : stream_bit;

  always @(posedge clk) if (bus.rsp_valid) rsp_count++;

  initial begin
    #3ms;
    $fatal(1, "FAIL global_timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_and_bringup(input int hold);
    int first;
    logic [127:0] v;
    trst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (hold) @(negedge clk);
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    tms_log.delete();
    tdi_log.delete();
    trst = 1'b0;
    first = -1;
    for (int k = 1; k <= 200 && first < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) first = k;
    end
    chk("bringup_ready_clk", first, 6 * TCK_CLKS + 1);
    chk("bringup_rises", tms_log.size(), 6);
    v = '0;
    foreach (tms_log[i]) v[i] = tms_log[i];
    chk("bringup_tms", v, 128'b011111);
    chk("bringup_idle_tck", tck, 1'b0);
  endtask

  task automatic run_cmd(input logic is_ir, input int len, input logic [DR_WIDTH-1:0] data,
                         input string tag);
    int eff, hdr, ncyc, cyc, bad, n;
    logic [DR_WIDTH-1:0] expv;
    logic exp_tms[$];
    eff  = (len > DR_WIDTH) ? DR_WIDTH : len;
    hdr  = is_ir ? 4 : 3;
    ncyc = (eff == 0) ? 0 : hdr + eff + 2 + PAD;
    expv = '0;
    for (int i = 0; i < eff; i++)
      expv[i] = loop_mode ? ((i == 0) ? 1'b0 : data[i-1]) : tdo_stream[hdr + i];
    exp_q.push_back(expv);
    if (eff > 0) begin
      exp_tms.push_back(1'b1);
      if (is_ir) exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      exp_tms.push_back(1'b0);
      for (int i = 0; i < eff; i++) exp_tms.push_back(i == eff - 1);
      exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      for (int i = 0; i < PAD; i++) exp_tms.push_back(1'b0);
    end

    n = 0;
    while (!bus.cmd_ready && n < 1000) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_idle_tck"}, tck, 1'b0);
    tms_log.delete();
    tdi_log.delete();
    -> cmd_start;
    bus.cmd_valid = 1'b1;
    bus.cmd_is_ir = is_ir;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = DR_WIDTH'({$urandom(), $urandom()});
    chk({tag, "_ready_drop"}, bus.cmd_ready, 1'b0);

    cyc = 0;
    while (!bus.rsp_valid && cyc < 64 * TCK_CLKS * 2) begin @(negedge clk); cyc++; end
    chk({tag, "_latency"}, cyc, ncyc * TCK_CLKS);
    chk({tag, "_rsp_data"}, bus.rsp_data, exp_q.pop_front());
    chk({tag, "_tck_cycles"}, tms_log.size(), ncyc);
    bad = (tms_log.size() != exp_tms.size()) ? 1 : 0;
    if (bad == 0) foreach (exp_tms[i]) if (tms_log[i] !== exp_tms[i]) bad++;
    chk({tag, "_tms_seq"}, bad, 0);
    bad = 0;
    for (int i = 0; i < eff; i++)
      if (hdr + i >= tdi_log.size() || tdi_log[hdr + i] !== data[i]) bad++;
    chk({tag, "_tdi_bits"}, bad, 0);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, bus.rsp_valid, 1'b0);
    chk({tag, "_ready_back"}, bus.cmd_ready, 1'b1);
    chk({tag, "_rsp_hold"}, bus.rsp_data, expv);
  endtask

  int n, cnt_before;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_is_ir = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    reset_and_bringup(3);

    // IR scan, target returns 5'b00001
    loop_mode  = 1'b0;
    tdo_stream = '0;
    tdo_stream[4] = 1'b1;
    run_cmd(1'b1, 5, DR_WIDTH'(5'b10001), "ir5");
    chk("ir5_value", bus.rsp_data, 41'h1);

    // full-width DR scan through a one-flop loopback
    loop_mode = 1'b1;
    run_cmd(1'b0, 41, 41'h1_2345_6789_A, "dr41_loop");
    chk("dr41_value", bus.rsp_data, 41'h2_468A_CF13_4);
    loop_mode = 1'b0;

    // clamp and zero length
    tdo_stream = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_cmd(1'b0, 63, DR_WIDTH'({$urandom(), $urandom()}), "clamp63");
    run_cmd(1'b1, 0, DR_WIDTH'({$urandom(), $urandom()}), "zero_len");
    chk("zero_len_value", bus.rsp_data, '0);

    // randomized scans
    for (int t = 0; t < 10; t++) begin
      tdo_stream = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 63),
              DR_WIDTH'({$urandom(), $urandom()}), "rand");
    end

    // abort a 41-bit DR scan during shift bit 20
    cnt_before = rsp_count;
    tdo_stream = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin @(negedge clk); n++; end
    tms_log.delete();
    tdi_log.delete();
    -> cmd_start;
    bus.cmd_valid = 1'b1;
    bus.cmd_is_ir = 1'b0;
    bus.cmd_len   = LEN_W'(41);
    bus.cmd_data  = '1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (tms_log.size() < 24 && n < 2000) begin @(negedge clk); n++; end
    chk("abort_reached_bit20", tms_log.size(), 24);
    #2 trst = 1'b1;
    #1;
    chk("abort_tck", tck, 1'b0);
    chk("abort_tms", tms, 1'b1);
    chk("abort_tdi", tdi, 1'b0);
    chk("abort_ready", bus.cmd_ready, 1'b0);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    reset_and_bringup(3);
    chk("abort_no_rsp", rsp_count, cnt_before);

    tdo_stream = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_cmd(1'b1, 5, DR_WIDTH'(5'b10110), "ir_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
